rom_car: RTL and testbench



---
 rtl/car_sprite_pkg.sv | 50 +++++
 rtl/car_addr_to_xy.sv | 20 ++
 rtl/rom_car.sv | 53 +++++
 tb/tb_rom_car.sv | 92 +++++++++
 4 files changed

// File: rtl/car_sprite_pkg.sv
// Shared constants for the car sprite ROM: geometry, palette and region bounds.
package car_sprite_pkg;

    localparam int SPR_W  = 80;
    localparam int SPR_H  = 121;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 3;
    localparam int XY_W   = 7;

    // Palette, bit2=R bit1=G bit0=B
    localparam logic [DATA_W-1:0] BODY_COLOR   = 3'b100;
    localparam logic [DATA_W-1:0] WHEEL_COLOR  = 3'b001;
    localparam logic [DATA_W-1:0] WINDOW_COLOR = 3'b011;
    localparam logic [DATA_W-1:0] LIGHT_COLOR  = 3'b110;
    localparam logic [DATA_W-1:0] BG_COLOR     = 3'b000;

    // Region bounds, all inclusive
    localparam logic [XY_W-1:0] LIGHT_Y_LO  = 7'd0;
    localparam logic [XY_W-1:0] LIGHT_Y_HI  = 7'd4;
    localparam logic [XY_W-1:0] LIGHT_XL_LO = 7'd14;
    localparam logic [XY_W-1:0] LIGHT_XL_HI = 7'd23;
    localparam logic [XY_W-1:0] LIGHT_XR_LO = 7'd56;
    localparam logic [XY_W-1:0] LIGHT_XR_HI = 7'd65;

    localparam logic [XY_W-1:0] WIN_X_LO    = 7'd20;
    localparam logic [XY_W-1:0] WIN_X_HI    = 7'd59;
    localparam logic [XY_W-1:0] WIN_YF_LO   = 7'd25;
    localparam logic [XY_W-1:0] WIN_YF_HI   = 7'd44;
    localparam logic [XY_W-1:0] WIN_YR_LO   = 7'd85;
    localparam logic [XY_W-1:0] WIN_YR_HI   = 7'd99;

    localparam logic [XY_W-1:0] BODY_X_LO   = 7'd10;
    localparam logic [XY_W-1:0] BODY_X_HI   = 7'd69;

    localparam logic [XY_W-1:0] WHL_XL_LO   = 7'd0;
    localparam logic [XY_W-1:0] WHL_XL_HI   = 7'd9;
    localparam logic [XY_W-1:0] WHL_XR_LO   = 7'd70;
    localparam logic [XY_W-1:0] WHL_XR_HI   = 7'd79;
    localparam logic [XY_W-1:0] WHL_YF_LO   = 7'd15;
    localparam logic [XY_W-1:0] WHL_YF_HI   = 7'd39;
    localparam logic [XY_W-1:0] WHL_YR_LO   = 7'd80;
    localparam logic [XY_W-1:0] WHL_YR_HI   = 7'd104;

    // Inclusive range test used by the colour priority logic
    function automatic logic in_rng(logic [XY_W-1:0] v, logic [XY_W-1:0] lo,
                                    logic [XY_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/car_addr_to_xy.sv
// Combinational split of a linear sprite address into x/y and an in-image flag.
module car_addr_to_xy
    import car_sprite_pkg::*;
(
    input  logic [ADDR_W-1:0] address_i,
    output logic [XY_W-1:0]   x_o,
    output logic [XY_W-1:0]   y_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] quo;

    // Division by a constant; the full-width quotient also yields the range flag,
    // since quotient < SPR_H exactly when address < SPR_W*SPR_H.
    assign quo     = ADDR_W'(address_i / ADDR_W'(SPR_W));
    assign y_o     = XY_W'(quo);
    assign x_o     = XY_W'(address_i % ADDR_W'(SPR_W));
    assign valid_o = (quo < ADDR_W'(SPR_H));

endmodule

// File: rtl/rom_car.sv
// Car sprite ROM: rule-generated pixel colour with a one-cycle registered read.
module rom_car
    import car_sprite_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    logic [XY_W-1:0]   x, y;
    logic              in_img;
    logic [DATA_W-1:0] data_d, data_q;

    car_addr_to_xy u_xy (
        .address_i (address),
        .x_o       (x),
        .y_o       (y),
        .valid_o   (in_img)
    );

    // Colour priority: headlights, windows, body, wheels, else background
    always_comb begin
        data_d = BG_COLOR;
        if (!in_img) begin
            data_d = BG_COLOR;
        end else if (in_rng(y, LIGHT_Y_LO, LIGHT_Y_HI) &&
                     (in_rng(x, LIGHT_XL_LO, LIGHT_XL_HI) ||
                      in_rng(x, LIGHT_XR_LO, LIGHT_XR_HI))) begin
            data_d = LIGHT_COLOR;
        end else if (in_rng(x, WIN_X_LO, WIN_X_HI) &&
                     (in_rng(y, WIN_YF_LO, WIN_YF_HI) ||
                      in_rng(y, WIN_YR_LO, WIN_YR_HI))) begin
            data_d = WINDOW_COLOR;
        end else if (in_rng(x, BODY_X_LO, BODY_X_HI)) begin
            data_d = BODY_COLOR;
        end else if ((in_rng(x, WHL_XL_LO, WHL_XL_HI) ||
                      in_rng(x, WHL_XR_LO, WHL_XR_HI)) &&
                     (in_rng(y, WHL_YF_LO, WHL_YF_HI) ||
                      in_rng(y, WHL_YR_LO, WHL_YR_HI))) begin
            data_d = WHEEL_COLOR;
        end
    end

    // Output register; synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) data_q <= BG_COLOR;
        else        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: tb/tb_rom_car.sv
// Self-checking bench for rom_car against a rule-level pixel model.
module tb_rom_car;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] address;
    logic [2:0]  data;

    int n_chk = 0;
    int n_err = 0;

    rom_car dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data    (data)
    );

    always #5 clk = ~clk;

    // Reference image computed straight from the drawing rules
    function automatic logic [2:0] ref_pix(int a);
        int x, y;
        if (a >= 80 * 121) return 3'b000;
        x = a % 80;
        y = a / 80;
        if (y <= 4 && ((x >= 14 && x <= 23) || (x >= 56 && x <= 65))) return 3'b110;
        if (x >= 20 && x <= 59 && ((y >= 25 && y <= 44) || (y >= 85 && y <= 99))) return 3'b011;
        if (x >= 10 && x <= 69) return 3'b100;
        if ((x <= 9 || x >= 70) && ((y >= 15 && y <= 39) || (y >= 80 && y <= 104))) return 3'b001;
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Present inputs, take one edge, and compare the registered result
    task automatic step(input int a, input logic rst_n, input string tag);
        logic [2:0] exp;
        address = a[13:0];
        reset   = rst_n;
        exp     = rst_n ? ref_pix(a) : 3'b000;
        @(posedge clk);
        #1;
        chk(tag, data, exp);
    endtask

    int probes[14] = '{0, 14, 1640, 2430, 1605, 7364, 9679, 9680, 16383, 8000,
                       1999, 2020, 2019, 399};

    initial begin
        reset   = 1'b0;
        address = 14'd14;
        @(negedge clk);

        // Reset hold, then release
        for (int i = 0; i < 3; i++) step(14, 1'b0, "rst_hold");
        step(14, 1'b1, "rst_release");
        chk("rst_release_light", data, 3'b110);

        // Directed region / boundary probes
        foreach (probes[i]) step(probes[i], 1'b1, $sformatf("probe_%0d", probes[i]));

        // Data must hold the previous address's pixel until the next edge
        address = 14'd2430;
        @(negedge clk);
        chk("latency_hold", data, ref_pix(399));
        @(posedge clk);
        #1;
        chk("latency_update", data, 3'b011);

        // Random addresses across the full range, occasional reset
        for (int i = 0; i < 400; i++) begin
            int a = int'($urandom_range(0, 16383));
            logic r = ($urandom_range(0, 19) != 0);
            step(a, r, $sformatf("rand_%0d", a));
        end

        // Full sweep with a single-cycle mid-stream reset
        for (int a = 0; a < 9680; a++)
            step(a, (a != 5000), $sformatf("sweep_%0d", a));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
